// File: rtl/fpgnix_apb_master.sv
// fpgnix_apb_master: single-outstanding APB3 initiator behind a valid/ready request/response port.
// Define FPGNIX_APB_MASTER_TIMEOUT_EN to add an ACCESS-phase watchdog that aborts after TIMEOUT_CYC cycles.
module fpgnix_apb_master #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  paddr_nxt;
  logic [31:0]        pwdata_nxt;
  logic               pwrite_nxt;
  logic               psel_nxt;
  logic               penable_nxt;
  logic               rsp_valid_nxt;
  logic [31:0]        rsp_rdata_nxt;
  logic               rsp_err_nxt;
  logic [CNT_W-1:0]   txn_cnt_nxt;
  logic               busy_nxt;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("fpgnix_apb_master: TIMEOUT_CYC must be within 1..65535");
  end

`ifdef FPGNIX_APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd_cnt, wd_cnt_nxt;
  logic        rsp_timeout_nxt;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    pwrite_nxt    = pwrite;
    psel_nxt      = psel;
    penable_nxt   = penable;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    txn_cnt_nxt   = txn_cnt;
`ifdef FPGNIX_APB_MASTER_TIMEOUT_EN
    wd_cnt_nxt      = wd_cnt;
    rsp_timeout_nxt = rsp_timeout;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          pwrite_nxt = req_write;
          paddr_nxt  = req_addr;
          pwdata_nxt = req_wdata;
          // Misaligned requests are answered locally without touching the bus
          if (req_addr[1:0] != 2'b00) begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
`ifdef FPGNIX_APB_MASTER_TIMEOUT_EN
            rsp_timeout_nxt = 1'b0;
`endif
          end else begin
            state_nxt   = SETUP;
            psel_nxt    = 1'b1;
            penable_nxt = 1'b0;
`ifdef FPGNIX_APB_MASTER_TIMEOUT_EN
            wd_cnt_nxt = '0;
`endif
          end
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_nxt     = RESP;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = pslverr;
          rsp_rdata_nxt = (pwrite || pslverr) ? 32'h0 : prdata;
`ifdef FPGNIX_APB_MASTER_TIMEOUT_EN
          rsp_timeout_nxt = 1'b0;
        end else if (wd_cnt == WD_LAST) begin
          state_nxt       = RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_timeout_nxt = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt + 16'd1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          txn_cnt_nxt   = txn_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      txn_cnt   <= '0;
      busy      <= 1'b0;
`ifdef FPGNIX_APB_MASTER_TIMEOUT_EN
      wd_cnt      <= '0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      pwrite    <= pwrite_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      txn_cnt   <= txn_cnt_nxt;
      busy      <= busy_nxt;
`ifdef FPGNIX_APB_MASTER_TIMEOUT_EN
      wd_cnt      <= wd_cnt_nxt;
      rsp_timeout <= rsp_timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fpgnix_apb_master.sv
// tb_fpgnix_apb_master: scoreboard bench with a programmable-wait APB slave model and bus monitor.
module tb_fpgnix_apb_master;

  localparam int ADDR_W      = 32;
  localparam int TIMEOUT_CYC = 8;
  localparam int CNT_W       = 4;

  logic              clk = 1'b0;
  logic              sys_rst;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic [CNT_W-1:0]  txn_cnt;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic        err;
    logic        tmo;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  fpgnix_apb_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy), .txn_cnt(txn_cnt),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: pready after slv_wait ACCESS wait cycles, never while hung
  int          slv_wait = 0;
  logic        slv_hang = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0;
  always @(posedge clk) acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
  assign pready  = psel && penable && !slv_hang && (acc_cnt == slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  // Bus monitor: protocol violations, ACCESS cycles, psel cycles, payload movement in ACCESS
  int          proto_viol = 0, acc_cycles = 0, psel_cycles = 0, addr_moves = 0;
  logic        prev_psel = 1'b0;
  logic [31:0] prev_paddr = '0, prev_pwdata = '0;
  always @(negedge clk) begin
    if (penable && !prev_psel) proto_viol++;
    if (penable && !psel) proto_viol++;
    if (psel && penable) begin
      acc_cycles++;
      if (paddr !== prev_paddr || pwdata !== prev_pwdata) addr_moves++;
    end
    if (psel) psel_cycles++;
    prev_psel   = psel;
    prev_paddr  = paddr;
    prev_pwdata = pwdata;
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] global timeout");
  end

  task automatic apply_reset();
    sys_rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0; exp_cnt = '0; sb.delete();
  endtask

  // Drives one request from a negedge, observes the response and returns just after a negedge
  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
      output int lat, output logic [31:0] r_rdata, output logic r_err, output logic r_tmo,
      output logic psel1, output logic pen1, output logic pen2,
      output logic [31:0] paddr1, output logic [31:0] pwdata1,
      output logic stable, output logic [CNT_W-1:0] cnt_o, output logic rdy_o);
    int guard = 0;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; psel1 = psel; pen1 = penable; paddr1 = paddr; pwdata1 = pwdata; pen2 = 1'b0;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk); lat++;
      if (lat == 2) pen2 = penable;
    end
    r_rdata = rsp_rdata; r_err = rsp_err; r_tmo = rsp_timeout;
    stable = 1'b1; cnt_o = '0; rdy_o = 1'b0;
    if (!rsp_valid) begin lat = -1; return; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_err !== r_err ||
          rsp_timeout !== r_tmo || req_ready !== 1'b0 || psel !== 1'b0) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0; cnt_o = txn_cnt; rdy_o = req_ready;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    req_addr = 32'h0000_0008; req_wdata = 32'hFFFF_FFFF; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({psel, penable, pwrite, busy, rsp_valid, rsp_err, rsp_timeout} !== 7'b0)
      begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {psel, penable, pwrite, busy, rsp_valid, rsp_err, rsp_timeout}); end
    checks++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0)
      begin errors++; $display("[TB] FAIL reset_data: paddr=%h pwdata=%h rdata=%h expected all 0", paddr, pwdata, rsp_rdata); end
    checks++;
    if (txn_cnt !== '0 || req_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL reset_cnt_ready: txn_cnt=%0d req_ready=%b expected 0/1", txn_cnt, req_ready); end
    sys_rst = 1'b0; req_valid = 1'b0; exp_cnt = '0;
  endtask

  task automatic test_zero_wait_write();
    int lat; logic [31:0] rd, pa, pw; logic er, tm, p1, e1, e2, st, rdy; logic [CNT_W-1:0] cn; exp_t e;
    slv_wait = 0; slv_err = 1'b0; slv_hang = 1'b0; slv_rdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b0, 1'b0, 32'h0, 3});
    do_xfer(1'b1, 32'h1A10_0004, 32'h0000_00A5, 0, lat, rd, er, tm, p1, e1, e2, pa, pw, st, cn, rdy);
    exp_cnt++;
    e = sb.pop_front();
    checks++;
    if (p1 !== 1'b1 || e1 !== 1'b0 || e2 !== 1'b1)
      begin errors++; $display("[TB] FAIL zw_phases: psel@1=%b penable@1=%b penable@2=%b expected 1/0/1", p1, e1, e2); end
    checks++;
    if (pa !== 32'h1A10_0004 || pw !== 32'h0000_00A5)
      begin errors++; $display("[TB] FAIL zw_payload: paddr=%h pwdata=%h expected 1a100004/000000a5", pa, pw); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("[TB] FAIL zw_latency: got %0d expected %0d", lat, e.lat); end
    checks++;
    if ({er, tm, rd} !== {e.err, e.tmo, e.rdata})
      begin errors++; $display("[TB] FAIL zw_rsp: err=%b tmo=%b rdata=%h expected %b/%b/%h", er, tm, rd, e.err, e.tmo, e.rdata); end
    checks++;
    if (cn !== exp_cnt || rdy !== 1'b1)
      begin errors++; $display("[TB] FAIL zw_cnt: txn_cnt=%0d req_ready=%b expected %0d/1", cn, rdy, exp_cnt); end
  endtask

  task automatic test_wait_read();
    int lat, ac, am; logic [31:0] rd, pa, pw; logic er, tm, p1, e1, e2, st, rdy; logic [CNT_W-1:0] cn; exp_t e;
    slv_wait = 3; slv_rdata = 32'hCAFE_F00D; ac = acc_cycles; am = addr_moves;
    sb.push_back('{1'b0, 1'b0, 32'hCAFE_F00D, 6});
    do_xfer(1'b0, 32'h4000_0010, 32'h1111_2222, 0, lat, rd, er, tm, p1, e1, e2, pa, pw, st, cn, rdy);
    exp_cnt++;
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("[TB] FAIL wait_latency: got %0d expected %0d", lat, e.lat); end
    checks++;
    if ({er, tm, rd} !== {e.err, e.tmo, e.rdata})
      begin errors++; $display("[TB] FAIL wait_rsp: err=%b tmo=%b rdata=%h expected %b/%b/%h", er, tm, rd, e.err, e.tmo, e.rdata); end
    checks++;
    if (acc_cycles - ac !== 4 || addr_moves !== am)
      begin errors++; $display("[TB] FAIL wait_access: access_cycles=%0d payload_moves=%0d expected 4/0", acc_cycles - ac, addr_moves - am); end
    checks++;
    if (cn !== exp_cnt) begin errors++; $display("[TB] FAIL wait_cnt: got %0d expected %0d", cn, exp_cnt); end
  endtask

  task automatic test_slverr_hold();
    int lat; logic [31:0] rd, pa, pw; logic er, tm, p1, e1, e2, st, rdy; logic [CNT_W-1:0] cn; exp_t e;
    slv_wait = 1; slv_err = 1'b1; slv_rdata = 32'h5555_AAAA;
    sb.push_back('{1'b1, 1'b0, 32'h0, 4});
    do_xfer(1'b0, 32'h2000_0020, 32'h0, 5, lat, rd, er, tm, p1, e1, e2, pa, pw, st, cn, rdy);
    exp_cnt++;
    slv_err = 1'b0;
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("[TB] FAIL slverr_latency: got %0d expected %0d", lat, e.lat); end
    checks++;
    if ({er, tm, rd} !== {e.err, e.tmo, e.rdata})
      begin errors++; $display("[TB] FAIL slverr_rsp: err=%b tmo=%b rdata=%h expected %b/%b/%h", er, tm, rd, e.err, e.tmo, e.rdata); end
    checks++;
    if (st !== 1'b1) begin errors++; $display("[TB] FAIL slverr_hold: stable=%b expected 1", st); end
    checks++;
    if (cn !== exp_cnt || rdy !== 1'b1)
      begin errors++; $display("[TB] FAIL slverr_cnt: txn_cnt=%0d req_ready=%b expected %0d/1", cn, rdy, exp_cnt); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2];
    addrs[0] = 32'h1A10_0002; addrs[1] = 32'h1A10_0003;
    for (int i = 0; i < 2; i++) begin
      int lat, pc; logic [31:0] rd, pa, pw; logic er, tm, p1, e1, e2, st, rdy; logic [CNT_W-1:0] cn; exp_t e;
      slv_rdata = 32'h7777_7777; pc = psel_cycles;
      sb.push_back('{1'b1, 1'b0, 32'h0, 1});
      do_xfer(i == 0, addrs[i], 32'h0BAD_0BAD, 1, lat, rd, er, tm, p1, e1, e2, pa, pw, st, cn, rdy);
      exp_cnt++;
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || p1 !== 1'b0 || psel_cycles !== pc)
        begin errors++; $display("[TB] FAIL misaligned_bus: lat=%0d psel@1=%b psel_cycles=%0d expected %0d/0/0", lat, p1, psel_cycles - pc, e.lat); end
      checks++;
      if ({er, tm, rd} !== {e.err, e.tmo, e.rdata} || cn !== exp_cnt)
        begin errors++; $display("[TB] FAIL misaligned_rsp: err=%b tmo=%b rdata=%h cnt=%0d expected %b/%b/%h/%0d", er, tm, rd, cn, e.err, e.tmo, e.rdata, exp_cnt); end
    end
  endtask

  task automatic test_stall();
    int lat, ac; logic [31:0] rd, pa, pw; logic er, tm, p1, e1, e2, st, rdy; logic [CNT_W-1:0] cn; exp_t e;
    int exp_acc;
    ac = acc_cycles;
`ifdef FPGNIX_APB_MASTER_TIMEOUT_EN
    slv_hang = 1'b1; slv_rdata = 32'h9999_9999; exp_acc = TIMEOUT_CYC;
    sb.push_back('{1'b1, 1'b1, 32'h0, 2 + TIMEOUT_CYC});
`else
    slv_wait = 20; slv_rdata = 32'h1234_5678; exp_acc = 21;
    sb.push_back('{1'b0, 1'b0, 32'h1234_5678, 23});
`endif
    do_xfer(1'b0, 32'h3000_0100, 32'h0, 1, lat, rd, er, tm, p1, e1, e2, pa, pw, st, cn, rdy);
    exp_cnt++;
    slv_hang = 1'b0; slv_wait = 0;
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected %0d", lat, e.lat); end
    checks++;
    if ({er, tm, rd} !== {e.err, e.tmo, e.rdata})
      begin errors++; $display("[TB] FAIL stall_rsp: err=%b tmo=%b rdata=%h expected %b/%b/%h", er, tm, rd, e.err, e.tmo, e.rdata); end
    checks++;
    if (acc_cycles - ac !== exp_acc || st !== 1'b1)
      begin errors++; $display("[TB] FAIL stall_access: access_cycles=%0d stable=%b expected %0d/1", acc_cycles - ac, st, exp_acc); end
    checks++;
    if (cn !== exp_cnt) begin errors++; $display("[TB] FAIL stall_cnt: got %0d expected %0d", cn, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    slv_hang = 1'b1;
    req_write = 1'b1; req_addr = 32'h1A10_0008; req_wdata = 32'h0000_0042; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1)
      begin errors++; $display("[TB] FAIL rstmid_access: psel=%b penable=%b expected 1/1", psel, penable); end
    sys_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0; exp_cnt = '0;
    checks++;
    if ({psel, penable, busy, rsp_valid, req_ready} !== 5'b00001 || txn_cnt !== '0)
      begin errors++; $display("[TB] FAIL rstmid_state: psel/pen/busy/rspv/rdy=%b txn_cnt=%0d expected 00001/0", {psel, penable, busy, rsp_valid, req_ready}, txn_cnt); end
    slv_hang = 1'b0; rsp_ready = 1'b1; seen = 1'b0;
    repeat (6) begin @(negedge clk); if (rsp_valid || psel) seen = 1'b1; end
    rsp_ready = 1'b0;
    checks++;
    if (seen !== 1'b0 || txn_cnt !== exp_cnt)
      begin errors++; $display("[TB] FAIL rstmid_quiet: activity=%b txn_cnt=%0d expected 0/%0d", seen, txn_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int t0, n;
    apply_reset();
    slv_wait = 0; slv_err = 1'b0;
    n = (1 << CNT_W) + 1;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      int lat; logic [31:0] rd, pa, pw, addr; logic er, tm, p1, e1, e2, st, rdy, w; logic [CNT_W-1:0] cn; exp_t e;
      w = 1'($urandom_range(0, 1));
      slv_rdata = $urandom;
      addr = {$urandom_range(0, 32'h00FF_FFFF), 2'b00};
      sb.push_back('{1'b0, 1'b0, w ? 32'h0 : slv_rdata, 3});
      do_xfer(w, addr, $urandom, 0, lat, rd, er, tm, p1, e1, e2, pa, pw, st, cn, rdy);
      exp_cnt++;
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || {er, tm, rd} !== {e.err, e.tmo, e.rdata} || cn !== exp_cnt || pa !== addr)
        begin errors++; $display("[TB] FAIL b2b_%0d: lat=%0d err=%b rdata=%h cnt=%0d paddr=%h expected %0d/%b/%h/%0d/%h", i, lat, er, rd, cn, pa, e.lat, e.err, e.rdata, exp_cnt, addr); end
    end
    checks++;
    if (cyc - t0 !== 4 * n) begin errors++; $display("[TB] FAIL b2b_throughput: cycles=%0d expected %0d", cyc - t0, 4 * n); end
    checks++;
    if (txn_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL b2b_wrap: txn_cnt=%0d expected %0d", txn_cnt, exp_cnt); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr_hold();
    test_misaligned();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (proto_viol !== 0) begin errors++; $display("[TB] FAIL apb_protocol: violations=%0d expected 0", proto_viol); end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_drain: left=%0d expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
